// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception receiver: records EPC/Cause/Status, issues the vector
// redirect on overflow or interrupt and the EPC redirect on ERET.
module cp0_exc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_3600),
  parameter logic [WIDTH-1:0] PRID_VAL   = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pc_in,
  input  logic             i_overflow,
  input  logic [5:0]       i_hw_int,
  input  logic             i_eret,
  input  logic             i_mtc0_we,
  input  logic [4:0]       i_cp0_sel,
  input  logic [WIDTH-1:0] i_mtc0_data,
  output logic [WIDTH-1:0] o_mfc0_data_c,
  output logic             o_redirect_c,
  output logic [WIDTH-1:0] o_redirect_pc_c,
  output logic             o_flush_c,
  output logic             o_exl
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;
  localparam logic [4:0] EXC_OV    = 5'd12;
  localparam logic [4:0] EXC_INT   = 5'd0;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_sync1;
  logic [5:0]       r_sync2;
  logic [5:0]       r_im;
  logic             r_ie;
  logic [4:0]       r_exc_code;
  logic [WIDTH-1:0] r_epc;

  logic             w_exl;
  logic             w_int_req;
  logic             w_exc_take;
  logic             w_mtc0_ok;
  logic             w_sr_wr;
  logic             w_redirect;
  logic             w_eret_redirect;

  // SR.EXL is the FSM state itself, so the two can never disagree
  assign w_exl      = (r_state == ST_HANDLER);
  assign w_int_req  = (|(r_sync2 & r_im)) & r_ie & ~w_exl;
  assign w_exc_take = i_overflow | w_int_req;
  assign w_mtc0_ok  = i_mtc0_we & ~w_exc_take & ~i_eret;
  assign w_sr_wr    = i_mtc0_we & (i_cp0_sel == SEL_SR);

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_hw_int;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Exception beats ERET, ERET beats MTC0; the SR write path drives EXL
  always_comb begin
    w_state_nxt     = r_state;
    w_redirect      = 1'b0;
    w_eret_redirect = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_exc_take) begin
          w_redirect  = 1'b1;
          w_state_nxt = ST_HANDLER;
        end else if (i_eret) begin
          w_redirect      = 1'b1;
          w_eret_redirect = 1'b1;
        end else if (w_sr_wr && i_mtc0_data[1]) begin
          w_state_nxt = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (w_exc_take) begin
          w_redirect = 1'b1;
        end else if (i_eret) begin
          w_redirect      = 1'b1;
          w_eret_redirect = 1'b1;
          w_state_nxt     = ST_NORMAL;
        end else if (w_sr_wr && !i_mtc0_data[1]) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // A nested fault only refreshes ExcCode; EPC keeps the first fault
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_im       <= '0;
      r_ie       <= 1'b0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else if (w_exc_take) begin
      r_exc_code <= i_overflow ? EXC_OV : EXC_INT;
      if (!w_exl) begin
        r_epc <= i_pc_in;
      end
    end else if (w_mtc0_ok) begin
      case (i_cp0_sel)
        SEL_SR: begin
          r_im <= i_mtc0_data[15:10];
          r_ie <= i_mtc0_data[0];
        end
        SEL_CAUSE: r_exc_code <= i_mtc0_data[6:2];
        SEL_EPC:   r_epc      <= i_mtc0_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_mfc0_data_c = '0;
    case (i_cp0_sel)
      SEL_SR: begin
        o_mfc0_data_c[15:10] = r_im;
        o_mfc0_data_c[1]     = w_exl;
        o_mfc0_data_c[0]     = r_ie;
      end
      SEL_CAUSE: begin
        o_mfc0_data_c[15:10] = r_sync2;
        o_mfc0_data_c[6:2]   = r_exc_code;
      end
      SEL_EPC:  o_mfc0_data_c = r_epc;
      SEL_PRID: o_mfc0_data_c = PRID_VAL;
      default: ;
    endcase
  end

  assign o_redirect_c    = i_rst_n & w_redirect;
  assign o_flush_c       = i_rst_n & w_redirect;
  assign o_redirect_pc_c = (i_rst_n && w_eret_redirect) ? r_epc : EXC_VECTOR;
  assign o_exl           = w_exl;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: driver pushes reference-model predictions,
// a mid-cycle monitor pops and compares against the DUT outputs.
module tb_cp0_exc_unit;

  localparam logic [31:0] VEC = 32'h0000_3600;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        exl;
    logic [31:0] mfc0;
    logic [4:0]  sel;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        overflow;
  logic [5:0]  hw_int;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  cp0_sel;
  logic [31:0] mtc0_data;
  logic [31:0] mfc0_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        exl;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  // Reference state, in architectural terms
  logic [5:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [5:0]  m_hist[$];

  cp0_exc_unit dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pc_in        (pc_in),
    .i_overflow     (overflow),
    .i_hw_int       (hw_int),
    .i_eret         (eret),
    .i_mtc0_we      (mtc0_we),
    .i_cp0_sel      (cp0_sel),
    .i_mtc0_data    (mtc0_data),
    .o_mfc0_data_c  (mfc0_data),
    .o_redirect_c   (redirect),
    .o_redirect_pc_c(redirect_pc),
    .o_flush_c      (flush),
    .o_exl          (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IP seen now is the hw_int value driven two cycles ago
  function automatic logic [5:0] m_ip();
    return m_hist[0];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] sel);
    case (sel)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {16'h0, m_ip(), 3'b000, m_code, 2'b00};
      5'd14:   return m_epc;
      5'd15:   return 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_clear();
    m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_code = '0; m_epc = '0;
    m_hist.delete();
    m_hist.push_back(6'h0);
    m_hist.push_back(6'h0);
  endtask

  task automatic rst_cycle(input logic [4:0] sel, input logic ov, input logic er);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0; overflow = ov; eret = er; mtc0_we = 1'b1;
    cp0_sel = sel; mtc0_data = 32'hFFFF_FFFF; pc_in = 32'h1234; hw_int = 6'h3F;
    m_clear();
    e.redirect = 1'b0; e.rpc = VEC; e.exl = 1'b0; e.mfc0 = m_read(sel); e.sel = sel;
    q.push_back(e);
  endtask

  task automatic cycle(input logic ov, input logic [31:0] pc, input logic er,
                       input logic we, input logic [4:0] sel,
                       input logic [31:0] data, input logic [5:0] hw);
    exp_t e;
    logic take, int_req, er_eff;
    @(posedge clk); #1;
    rst_n = 1'b1; overflow = ov; pc_in = pc; eret = er; mtc0_we = we;
    cp0_sel = sel; mtc0_data = data; hw_int = hw;
    int_req = (|(m_ip() & m_im)) && m_ie && !m_exl;
    take    = ov || int_req;
    er_eff  = er && !take;
    e.redirect = take || er_eff;
    e.rpc      = er_eff ? m_epc : VEC;
    e.exl      = m_exl;
    e.mfc0     = m_read(sel);
    e.sel      = sel;
    q.push_back(e);
    if (take) begin
      if (!m_exl) begin
        m_epc = pc;
        m_exl = 1'b1;
      end
      m_code = ov ? 5'd12 : 5'd0;
    end else if (er_eff) begin
      m_exl = 1'b0;
    end else if (we) begin
      case (sel)
        5'd12: begin m_im = data[15:10]; m_exl = data[1]; m_ie = data[0]; end
        5'd13: m_code = data[6:2];
        5'd14: m_epc = data;
        default: ;
      endcase
    end
    void'(m_hist.pop_front());
    m_hist.push_back(hw);
  endtask

  task automatic idle(input logic [4:0] sel, input logic [5:0] hw);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, sel, 32'h0, hw);
  endtask

  // Monitor: every cycle the DUT presents a response; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (redirect !== e.redirect) begin
          errors++;
          $display("FAIL redirect t=%0t got=%0b exp=%0b", $time, redirect, e.redirect);
        end
        checks++;
        if (flush !== e.redirect) begin
          errors++;
          $display("FAIL flush t=%0t got=%0b exp=%0b", $time, flush, e.redirect);
        end
        checks++;
        if (exl !== e.exl) begin
          errors++;
          $display("FAIL exl t=%0t got=%0b exp=%0b", $time, exl, e.exl);
        end
        checks++;
        if (mfc0_data !== e.mfc0) begin
          errors++;
          $display("FAIL mfc0 sel=%0d t=%0t got=%h exp=%h", e.sel, $time, mfc0_data, e.mfc0);
        end
        if (e.redirect || !rst_n) begin
          checks++;
          if (redirect_pc !== e.rpc) begin
            errors++;
            $display("FAIL redirect_pc t=%0t got=%h exp=%h", $time, redirect_pc, e.rpc);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0]  hw;
    logic [4:0]  sel;
    logic [31:0] data;
    rst_n = 1'b0; overflow = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
    cp0_sel = '0; mtc0_data = '0; pc_in = '0; hw_int = '0;
    m_clear();

    rst_cycle(5'd12, 1'b1, 1'b1);
    rst_cycle(5'd13, 1'b0, 1'b0);
    rst_cycle(5'd15, 1'b0, 1'b1);

    // Overflow, readback, nested fault, return
    cycle(1'b1, 32'h3040, 1'b0, 1'b0, 5'd14, 32'h0, 6'h0);
    idle(5'd14, 6'h0);
    idle(5'd13, 6'h0);
    cycle(1'b1, 32'h3608, 1'b0, 1'b0, 5'd14, 32'h0, 6'h0);
    idle(5'd14, 6'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 5'd12, 32'h0, 6'h0);
    idle(5'd12, 6'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 5'd12, 32'h0, 6'h0);

    // Async reset in the middle of a handler
    cycle(1'b1, 32'h5000, 1'b0, 1'b0, 5'd14, 32'h0, 6'h0);
    idle(5'd12, 6'h0);
    rst_cycle(5'd12, 1'b1, 1'b1);
    rst_cycle(5'd13, 1'b0, 1'b0);
    rst_cycle(5'd14, 1'b0, 1'b0);

    // Interrupt enabled, then IE=0, then IM=0
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 6'h0);
    for (int i = 0; i < 4; i++) idle(5'd13, 6'h01);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 5'd13, 32'h0, 6'h00);
    for (int i = 0; i < 3; i++) idle(5'd12, 6'h00);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 5'd12, 32'h0, 6'h00);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0400, 6'h00);
    for (int i = 0; i < 4; i++) idle(5'd13, 6'h01);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0001, 6'h01);
    for (int i = 0; i < 4; i++) idle(5'd13, 6'h3F);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0000, 6'h00);
    for (int i = 0; i < 2; i++) idle(5'd12, 6'h00);

    // Overflow + ERET + MTC0 EPC in one cycle
    cycle(1'b1, 32'h7770, 1'b1, 1'b1, 5'd14, 32'hDEAD_BEEF, 6'h00);
    idle(5'd14, 6'h00);
    idle(5'd12, 6'h00);

    // Randomized traffic against the reference model
    hw = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_cycle(5'($urandom_range(10, 16)), 1'($urandom), 1'($urandom));
        continue;
      end
      if ($urandom_range(0, 7) == 0) hw = 6'($urandom);
      sel  = 5'($urandom_range(10, 16));
      data = $urandom;
      cycle(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), sel, data, hw);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
